// File: rtl/conv_accel_pkg.sv
// conv_accel shared types and constants.
// Kernel weights, bias, bank selects and FSM states.
package conv_pkg;

  localparam int DW    = 20;
  localparam int IMG_W = 64;
  localparam int AW    = 12;

  localparam logic signed [DW-1:0] K0 = 20'sh0A89E;
  localparam logic signed [DW-1:0] K1 = 20'sh092D5;
  localparam logic signed [DW-1:0] K2 = 20'sh06D43;
  localparam logic signed [DW-1:0] K3 = 20'sh01004;
  localparam logic signed [DW-1:0] K4 = 20'shF8F71;
  localparam logic signed [DW-1:0] K5 = 20'shF6E54;
  localparam logic signed [DW-1:0] K6 = 20'shFA6D7;
  localparam logic signed [DW-1:0] K7 = 20'shFC834;
  localparam logic signed [DW-1:0] K8 = 20'shFAC19;
  localparam logic signed [DW-1:0] BIAS = 20'sh01310;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    L0_FETCH,
    L0_WRITE,
    L1_READ,
    L1_WRITE,
    DONE
  } state_t;

  function automatic logic signed [DW-1:0] kern(
    input logic [1:0] kr,
    input logic [1:0] kc
  );
    logic signed [DW-1:0] w;
    unique case ({kr, kc})
      4'h0:    w = K0;
      4'h1:    w = K1;
      4'h2:    w = K2;
      4'h4:    w = K3;
      4'h5:    w = K4;
      4'h6:    w = K5;
      4'h8:    w = K6;
      4'h9:    w = K7;
      4'hA:    w = K8;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/conv_accel_if.sv
// Image ROM / result memory bus of conv_accel.
// master = accelerator, slave = memories and host.
interface conv_accel_if;

  logic                     ready;
  logic                     busy;
  logic [conv_pkg::AW-1:0]  iaddr;
  logic [conv_pkg::DW-1:0]  idata;
  logic                     cwr;
  logic [conv_pkg::AW-1:0]  caddr_wr;
  logic [conv_pkg::DW-1:0]  cdata_wr;
  logic                     crd;
  logic [conv_pkg::AW-1:0]  caddr_rd;
  logic [conv_pkg::DW-1:0]  cdata_rd;
  logic [2:0]               csel;

  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr,
    output cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr,
    input  cdata_wr, crd, caddr_rd, csel
  );

endinterface

// File: rtl/conv_accel_mac.sv
// Signed MAC for one 3x3 window, then bias,
// round-half-up and ReLU down to a 20-bit word.
module conv_mac
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] din,
  input  logic signed [DW-1:0] wgt,
  output logic [DW-1:0]        res
);

  localparam int AccW = 44;

  localparam logic signed [AccW-1:0] BIAS_SH =
    {{(AccW-DW-16){BIAS[DW-1]}}, BIAS, 16'h0};
  localparam logic signed [AccW-1:0] RND = 44'sd32768;

  logic signed [2*DW-1:0] prod;
  logic signed [AccW-1:0] acc;
  logic signed [AccW-1:0] sum;
  logic                   unused_bits;

  assign prod = din * wgt;
  assign sum  = acc + BIAS_SH + RND;
  assign res  = sum[AccW-1] ? '0 : sum[DW+15:16];

  assign unused_bits =
    ^{sum[AccW-2:DW+16], sum[15:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc +
        {{(AccW-2*DW){prod[2*DW-1]}}, prod};
    end
  end

endmodule

// File: rtl/conv_accel.sv
// conv_accel: 3x3 conv + bias + ReLU (layer 0),
// then 2x2 stride-2 max-pool (layer 1).
module conv_accel
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  conv_accel_if.master bus
);

  localparam int NPIX = IMG_W * IMG_W;

  state_t               state;
  logic [AW-1:0]        pix;
  logic [1:0]           kr;
  logic [1:0]           kc;
  logic                 drain;
  logic                 pend_v;
  logic signed [DW-1:0] pend_w;
  logic [9:0]           pool;
  logic [1:0]           q;
  logic                 rpend;
  logic [DW-1:0]        mx;

  logic [6:0]           nr;
  logic [6:0]           nc;
  logic                 nvalid;
  logic                 mac_clr;
  logic [DW-1:0]        mac_res;

  // Bit 6 set means the neighbour fell off the image edge.
  assign nr = {1'b0, pix[11:6]} + {5'b0, kr} - 7'd1;
  assign nc = {1'b0, pix[5:0]} + {5'b0, kc} - 7'd1;
  assign nvalid = ~nr[6] & ~nc[6];

  assign mac_clr = (state == IDLE) ||
                   (state == L0_WRITE);

  conv_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (pend_v),
    .din   (bus.idata),
    .wgt   (pend_w),
    .res   (mac_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pix          <= '0;
      kr           <= '0;
      kc           <= '0;
      drain        <= 1'b0;
      pend_v       <= 1'b0;
      pend_w       <= '0;
      pool         <= '0;
      q            <= '0;
      rpend        <= 1'b0;
      mx           <= '0;
      bus.busy     <= 1'b0;
      bus.iaddr    <= '0;
      bus.cwr      <= 1'b0;
      bus.caddr_wr <= '0;
      bus.cdata_wr <= '0;
      bus.crd      <= 1'b0;
      bus.caddr_rd <= '0;
      bus.csel     <= CSEL_NONE;
    end else begin
      case (state)
        IDLE: begin
          bus.cwr <= 1'b0;
          bus.crd <= 1'b0;
          if (bus.ready && !bus.busy) begin
            bus.busy <= 1'b1;
            pix      <= '0;
            kr       <= '0;
            kc       <= '0;
            drain    <= 1'b0;
            pend_v   <= 1'b0;
            state    <= L0_FETCH;
          end
        end

        // One neighbour address per cycle; data
        // lands one cycle later and is accumulated.
        L0_FETCH: begin
          bus.cwr <= 1'b0;
          if (!drain) begin
            bus.iaddr <= {nr[5:0], nc[5:0]};
            pend_v    <= nvalid;
            pend_w    <= kern(kr, kc);
            if (kc == 2'd2) begin
              kc <= '0;
              if (kr == 2'd2) begin
                kr    <= '0;
                drain <= 1'b1;
              end else begin
                kr <= kr + 2'd1;
              end
            end else begin
              kc <= kc + 2'd1;
            end
          end else begin
            pend_v <= 1'b0;
            drain  <= 1'b0;
            state  <= L0_WRITE;
          end
        end

        L0_WRITE: begin
          bus.cwr      <= 1'b1;
          bus.csel     <= CSEL_L0;
          bus.caddr_wr <= pix;
          bus.cdata_wr <= mac_res;
          if (pix == AW'(NPIX - 1)) begin
            pool  <= '0;
            q     <= '0;
            drain <= 1'b0;
            rpend <= 1'b0;
            mx    <= '0;
            state <= L1_READ;
          end else begin
            pix   <= pix + 12'd1;
            state <= L0_FETCH;
          end
        end

        L1_READ: begin
          bus.cwr <= 1'b0;
          if (rpend && (bus.cdata_rd > mx)) begin
            mx <= bus.cdata_rd;
          end
          if (!drain) begin
            bus.crd      <= 1'b1;
            bus.csel     <= CSEL_L0;
            bus.caddr_rd <= {pool[9:5], q[1],
                             pool[4:0], q[0]};
            rpend        <= 1'b1;
            q            <= q + 2'd1;
            if (q == 2'd3) begin
              drain <= 1'b1;
            end
          end else begin
            bus.crd <= 1'b0;
            rpend   <= 1'b0;
            drain   <= 1'b0;
            state   <= L1_WRITE;
          end
        end

        L1_WRITE: begin
          bus.cwr      <= 1'b1;
          bus.csel     <= CSEL_L1;
          bus.caddr_wr <= {2'b00, pool};
          bus.cdata_wr <= mx;
          mx           <= '0;
          if (pool == 10'h3FF) begin
            state <= DONE;
          end else begin
            pool  <= pool + 10'd1;
            state <= L1_READ;
          end
        end

        DONE: begin
          bus.cwr  <= 1'b0;
          bus.crd  <= 1'b0;
          bus.csel <= CSEL_NONE;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_accel.sv
// Random + composite-image bench for conv_accel
// against a plain-arithmetic CNN reference.
module tb_conv_accel;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  conv_accel_if bus ();

  conv_accel dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [19:0] kraw [9] = '{
    20'h0A89E, 20'h092D5, 20'h06D43,
    20'h01004, 20'hF8F71, 20'hF6E54,
    20'hFA6D7, 20'hFC834, 20'hFAC19
  };
  localparam longint BIAS_I = 'h01310;

  logic [19:0] img [4096];
  logic [19:0] l0m [4096];
  logic [19:0] l1m [1024];
  logic [19:0] g0  [4096];
  logic [19:0] g1  [1024];
  int          l0_job [4096];
  int          l1_job [1024];
  int          job = 0;

  typedef struct packed {
    logic [11:0] a;
    logic [19:0] d;
    logic [2:0]  s;
  } wr_t;
  wr_t wlog [$];

  int   n_l0w = 0, n_l1w = 0, n_overlap = 0;
  int   n_badsel = 0, n_order = 0, n_falls = 0;
  int   last_l1_job = -1;
  logic prev_busy = 1'b0;
  int   n_vec = 0, n_err = 0;

  // Result memory: latches writes on the rising edge.
  always @(posedge clk) begin
    if (bus.crd && bus.cwr) n_overlap++;
    if (bus.crd && bus.csel != 3'b001) n_badsel++;
    if (bus.cwr) begin
      wlog.push_back({bus.caddr_wr, bus.cdata_wr,
                      bus.csel});
      if (bus.csel == 3'b001) begin
        l0m[bus.caddr_wr]    = bus.cdata_wr;
        l0_job[bus.caddr_wr] = job;
        n_l0w++;
        if (last_l1_job == job) n_order++;
      end else if (bus.csel == 3'b011) begin
        l1m[bus.caddr_wr[9:0]]    = bus.cdata_wr;
        l1_job[bus.caddr_wr[9:0]] = job;
        last_l1_job = job;
        n_l1w++;
      end else begin
        n_badsel++;
      end
    end
  end

  always @(negedge clk) begin
    bus.idata    = img[bus.iaddr];
    bus.cdata_rd = l0m[bus.caddr_rd];
    if (prev_busy && !bus.busy) n_falls++;
    prev_busy = bus.busy;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [19:0] v);
    return v[19] ? longint'(v) - 64'sd1048576
                 : longint'(v);
  endfunction

  function automatic logic [19:0] ref0(int r, int c);
    longint acc = 0;
    longint s;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        if (rr >= 0 && rr < 64 && cc >= 0 && cc < 64)
          acc += sx(img[rr*64+cc]) *
                 sx(kraw[(dr+1)*3 + dc + 1]);
      end
    end
    s = acc + BIAS_I * 65536 + 32768;
    if (s < 0) return 20'h0;
    return s[35:16];
  endfunction

  function automatic void build_gold();
    logic [19:0] m, v;
    for (int i = 0; i < 4096; i++)
      g0[i] = ref0(i / 64, i % 64);
    for (int pr = 0; pr < 32; pr++) begin
      for (int pc = 0; pc < 32; pc++) begin
        m = 20'h0;
        for (int d = 0; d < 4; d++) begin
          v = g0[(2*pr + d/2)*64 + 2*pc + d%2];
          if (v > m) m = v;
        end
        g1[pr*32+pc] = m;
      end
    end
  endfunction

  task automatic check_outputs_zero(input string p);
    check({p, "_busy"}, 32'(bus.busy), 0);
    check({p, "_cwr"}, 32'(bus.cwr), 0);
    check({p, "_crd"}, 32'(bus.crd), 0);
    check({p, "_csel"}, 32'(bus.csel), 0);
    check({p, "_iaddr"}, 32'(bus.iaddr), 0);
    check({p, "_caddr_wr"}, 32'(bus.caddr_wr), 0);
    check({p, "_caddr_rd"}, 32'(bus.caddr_rd), 0);
    check({p, "_cdata_wr"}, 32'(bus.cdata_wr), 0);
  endtask

  int b_l0, b_l1, b_ov, b_bs, b_or, b_f;
  int cyc, miss, nlog, base;
  wr_t e;

  initial begin
    reset     = 1'b0;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Composite: -1 corner, impulse in zeros, +1 block.
    for (int i = 0; i < 4096; i++)
      img[i] = 20'($urandom);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r*64+c] = 20'hF0000;
    for (int r = 8; r < 24; r++)
      for (int c = 8; c < 24; c++)
        img[r*64+c] = 20'h0;
    img[10*64+10] = 20'h10000;
    for (int r = 40; r < 48; r++)
      for (int c = 40; c < 48; c++)
        img[r*64+c] = 20'h10000;
    build_gold();
    job = 1;

    b_l0 = n_l0w; b_l1 = n_l1w; b_ov = n_overlap;
    b_bs = n_badsel; b_or = n_order; b_f = n_falls;
    bus.ready = 1'b1;
    cyc = 0;
    while (!bus.busy && cyc < 2) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_rise", 32'(bus.busy), 1);
    repeat (3) @(negedge clk);
    bus.ready = 1'b0;
    repeat (2000) @(negedge clk);
    bus.ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.ready = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 70000) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_fall", 32'(bus.busy), 0);
    repeat (4) @(negedge clk);
    check("busy_falls_once", 32'(n_falls - b_f), 1);
    check("l0_writes", 32'(n_l0w - b_l0), 4096);
    check("l1_writes", 32'(n_l1w - b_l1), 1024);
    check("rd_wr_overlap", 32'(n_overlap - b_ov), 0);
    check("bad_csel", 32'(n_badsel - b_bs), 0);
    check("l0_after_l1", 32'(n_order - b_or), 0);
    check("idle_csel", 32'(bus.csel), 0);
    check("idle_cwr", 32'(bus.cwr), 0);
    check("idle_crd", 32'(bus.crd), 0);

    check("neg_l0_0", 32'(l0m[0]), 'h1A0FE);
    check("neg_l0_1", 32'(l0m[1]), 'h1EA23);
    check("neg_l0_64", 32'(l0m[64]), 'h0A0E6);
    check("neg_l0_int", 32'(l0m[3*64+3]), 'h0416D);
    check("neg_l1_0", 32'(l1m[0]), 'h1EA23);
    check("imp_l0_a", 32'(l0m[11*64+11]), 'h0BBAE);
    check("imp_l0_b", 32'(l0m[11*64+10]), 'h0A5E5);
    check("imp_l0_c", 32'(l0m[9*64+9]), 'h00000);
    check("imp_l1", 32'(l1m[5*32+5]), 'h0BBAE);
    check("zero_l0", 32'(l0m[20*64+20]), 'h01310);
    check("zero_l1", 32'(l1m[10*32+10]), 'h01310);
    check("pos_l0", 32'(l0m[43*64+43]), 'h00000);
    check("pos_l1", 32'(l1m[21*32+21]), 'h00000);

    miss = 0;
    for (int i = 0; i < 4096; i++)
      if (l0_job[i] != job) miss++;
    check("l0_cover", 32'(miss), 0);
    miss = 0;
    for (int i = 0; i < 1024; i++)
      if (l1_job[i] != job) miss++;
    check("l1_cover", 32'(miss), 0);
    for (int i = 0; i < 4096; i++)
      check($sformatf("l0[%0d]", i),
            32'(l0m[i]), 32'(g0[i]));
    for (int i = 0; i < 1024; i++)
      check($sformatf("l1[%0d]", i),
            32'(l1m[i]), 32'(g1[i]));

    // Random image, aborted by reset mid layer 0.
    for (int i = 0; i < 4096; i++)
      img[i] = 20'($urandom);
    build_gold();
    job = 2;
    bus.ready = 1'b1;
    cyc = 0;
    while (!bus.busy && cyc < 2) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_rise2", 32'(bus.busy), 1);
    bus.ready = 1'b0;
    repeat (3000) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_outputs_zero("abort");
    @(negedge clk);
    reset = 1'b1;
    nlog = wlog.size();
    repeat (20) @(negedge clk);
    check("no_resume", 32'(bus.busy), 0);
    check("no_writes", 32'(wlog.size() - nlog), 0);

    job  = 3;
    base = wlog.size();
    bus.ready = 1'b1;
    cyc = 0;
    while (wlog.size() < base + 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    bus.ready = 1'b0;
    check("restart_writes",
          32'(wlog.size() >= base + 3), 1);
    for (int k = 0; k < 3; k++) begin
      e = (base + k < wlog.size()) ? wlog[base+k]
                                   : '1;
      check($sformatf("restart_addr%0d", k),
            32'(e.a), 32'(k));
      check($sformatf("restart_data%0d", k),
            32'(e.d), 32'(g0[k]));
      check($sformatf("restart_csel%0d", k),
            32'(e.s), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
